multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle MIPS control FSM; successor to the single-cycle opcode decoder.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, with parametrised
//  wait states for instruction memory, data memory and multiplier latency.
//  Emits per-state datapath strobes plus the static decode fields (AluOp, RegDst, ...).
//  Sits between the instruction register and the multi-cycle datapath.
// PARAMETERS
//  IMEM_LAT  1  cycles FETCH holds MemRead before the instruction is valid (>=1)
//  DMEM_LAT  1  cycles MEM holds the data access (>=1)
//  MUL_LAT   1  cycles EXEC is held for opcode 011100 (mul class) (>=1)
// PORTS
//  Clk           in   1  clock, rising edge
//  Rst           in   1  synchronous reset, active-high
//  Opcode        in   6  instruction bits 31:26 (valid in DECODE)
//  Bit17         in   1  instruction bit 16 (selects bgez/bltz)
//  Stall         in   1  freeze: state and counters hold, all strobes forced 0
//  PCWrite       out  1  strobe: PC load (PC+4 or jump target)
//  PCWriteCond   out  1  strobe: PC load if branch condition true
//  IRWrite       out  1  strobe: latch instruction register
//  RegWrite      out  1  strobe: register file write
//  HiLoWrite     out  1  strobe: HI/LO write (mul class)
//  MemRead       out  1  level: memory read (instruction in FETCH, data in MEM)
//  MemWrite      out  1  strobe: data memory write
//  IorD          out  1  0 = PC addresses memory, 1 = ALU result
//  Jump, Link    out  1  jump-target select / write $ra with PC+4 (jal)
//  AluSrc, RegDst, MemtoReg, SEControl, LS_Control, LS_SEControl, Comp_Control
//                out  1  static decode fields, meanings unchanged from single-cycle
//  AluOp         out  4  ALU-control class code
//  D_MemWrite_S  out  2  store size: 0 word, 1 byte, 2 half
//  Illegal       out  1  one-cycle pulse when an undecoded opcode reaches DECODE
//  State         out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
// BEHAVIOUR
//  Reset: State=FETCH; wait counter=0; latched op_q=0, b17_q=0; all outputs 0 on
//   the first cycle after reset (including while in FETCH).
//  Decode fields are driven from op_q/b17_q, latched at the end of DECODE; they are
//   stable from EXEC through WB.
//  - AluOp: R 0, mul 1, seh/seb 2, andi 3, ori 4, xori 5, addi 6, addiu 7,
//    slti 8, sltiu 9, lui 10, lw/lb/lh/sw/sb/sh 6, bgtz/blez 11, bltz/bgez 12,
//    beq/bne 13.
//  - Comp_Control=1 for blez, bne, and opcode 000001 with Bit17=1.
//  - SEControl=0 for andi/ori/xori, else 1.
//  - RegDst=1 for R/mul/seh only (lh now uses rt).
//  - MemtoReg=0 for loads, else 1.
//  - LS_Control=1 for lb/lh/sb/sh; LS_SEControl=1 for lh/sh.
//  - D_MemWrite_S: sb=1, sh=2, else 0.
//  FETCH:
//  - IorD=0 and MemRead=1 for IMEM_LAT cycles.
//  - Last cycle: IRWrite=1, PCWrite=1, then -> DECODE.
//  DECODE (1 cycle): latch Opcode/Bit17.
//  - j: PCWrite=1, Jump=1, then -> FETCH.
//  - jal: same as j, plus Link=1 and RegWrite=1, then -> FETCH.
//  - Undecoded opcode: Illegal=1, then -> FETCH (no PC/reg/mem effect).
//  - Otherwise -> EXEC.
//  EXEC:
//  - Branch: PCWriteCond=1 for 1 cycle, then -> FETCH.
//  - Mul: held MUL_LAT cycles, then -> WB.
//  - Load/store: 1 cycle, then -> MEM.
//  - Other ALU ops: 1 cycle, then -> WB.
//  MEM:
//  - IorD=1 for DMEM_LAT cycles.
//  - Loads: MemRead=1 for all those cycles, then -> WB.
//  - Stores: MemWrite=1 on the last cycle only, then -> FETCH.
//  WB (1 cycle): RegWrite=1, except mul class (HiLoWrite=1, RegWrite=0); then -> FETCH.
//  Wait counter: counts 0..LAT-1, clears on every state change; no overflow possible.
//  Stall has priority over sequencing. Rst has priority over Stall. Rst mid-instruction
//   aborts it; no strobe is issued on the reset cycle.
//  Nominal cycle counts (all LAT=1): j 2, branch 3, sw 4, R/I-ALU 4, lw 5.
// TESTING
//  1. Rst high 2 cycles, then low -> State=0 and all strobes 0 on the first post-reset cycle.
//  2. Opcode 000000, all LAT=1 -> States 0,1,2,4,0; RegWrite=1 only in WB; RegDst=1, AluOp=0.
//  3. lw (100011), DMEM_LAT=3 -> MEM lasts 3 cycles with MemRead=1, IorD=1; WB RegWrite=1, MemtoReg=0.
//  4. sh (101001) -> MemWrite pulses once at end of MEM, D_MemWrite_S=2; returns to FETCH with RegWrite never 1.
//  5. 000001 with Bit17=1 -> AluOp=12, Comp_Control=1, PCWriteCond=1 in EXEC; jal -> PCWrite, Link and RegWrite together in DECODE.
//  6. Stall held 3 cycles in MEM, then opcode 111111 -> State frozen, no strobes; then Illegal=1 pulse and return to FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Bundle between the multi-cycle MIPS control FSM and the datapath it drives:
// instruction fields and stall in, per-state strobes and static decode fields out.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic       bit17;
    logic       stall;

    logic       pcwrite;
    logic       pcwritecond;
    logic       irwrite;
    logic       regwrite;
    logic       hilowrite;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       jump;
    logic       link;
    logic       alusrc;
    logic       regdst;
    logic       memtoreg;
    logic       secontrol;
    logic       ls_control;
    logic       ls_secontrol;
    logic       comp_control;
    logic [3:0] aluop;
    logic [1:0] d_memwrite_s;
    logic       illegal;
    logic [2:0] state;

    modport master (
        input  opcode, bit17, stall,
        output pcwrite, pcwritecond, irwrite, regwrite, hilowrite, memread, memwrite,
               iord, jump, link, alusrc, regdst, memtoreg, secontrol, ls_control,
               ls_secontrol, comp_control, aluop, d_memwrite_s, illegal, state
    );

    modport slave (
        output opcode, bit17, stall,
        input  pcwrite, pcwritecond, irwrite, regwrite, hilowrite, memread, memwrite,
               iord, jump, link, alusrc, regdst, memtoreg, secontrol, ls_control,
               ls_secontrol, comp_control, aluop, d_memwrite_s, illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with parametrised wait
// states for instruction memory, data memory and multiplier latency.
module multicycle_controller #(
    parameter int IMEM_LAT = 1,
    parameter int DMEM_LAT = 1,
    parameter int MUL_LAT  = 1
) (
    input logic                    clk,
    input logic                    rst,
    multicycle_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_MUL, C_LOAD, C_STORE, C_BRANCH, C_J, C_JAL, C_ILL
    } class_t;

    typedef struct packed {
        class_t     cls;
        logic [3:0] aluop;
        logic       alusrc;
        logic       regdst;
        logic       memtoreg;
        logic       secontrol;
        logic       ls_control;
        logic       ls_secontrol;
        logic       comp_control;
        logic [1:0] memwrite_s;
    } dec_t;

    localparam int MAXLAT = (IMEM_LAT > DMEM_LAT) ?
                            ((IMEM_LAT > MUL_LAT) ? IMEM_LAT : MUL_LAT) :
                            ((DMEM_LAT > MUL_LAT) ? DMEM_LAT : MUL_LAT);
    localparam int CW = $clog2(MAXLAT + 1);

    function automatic dec_t decode(input logic [5:0] op, input logic b17);
        dec_t d;
        d           = '0;
        d.cls       = C_ILL;
        d.secontrol = 1'b1;
        d.memtoreg  = 1'b1;
        case (op)
            6'b000000: begin d.cls = C_ALU; d.aluop = 4'd0; d.regdst = 1'b1; end
            6'b011100: begin d.cls = C_MUL; d.aluop = 4'd1; d.regdst = 1'b1; end
            6'b011111: begin d.cls = C_ALU; d.aluop = 4'd2; d.regdst = 1'b1; end
            6'b001100: begin d.cls = C_ALU; d.aluop = 4'd3; d.alusrc = 1'b1; d.secontrol = 1'b0; end
            6'b001101: begin d.cls = C_ALU; d.aluop = 4'd4; d.alusrc = 1'b1; d.secontrol = 1'b0; end
            6'b001110: begin d.cls = C_ALU; d.aluop = 4'd5; d.alusrc = 1'b1; d.secontrol = 1'b0; end
            6'b001000: begin d.cls = C_ALU; d.aluop = 4'd6; d.alusrc = 1'b1; end
            6'b001001: begin d.cls = C_ALU; d.aluop = 4'd7; d.alusrc = 1'b1; end
            6'b001010: begin d.cls = C_ALU; d.aluop = 4'd8; d.alusrc = 1'b1; end
            6'b001011: begin d.cls = C_ALU; d.aluop = 4'd9; d.alusrc = 1'b1; end
            6'b001111: begin d.cls = C_ALU; d.aluop = 4'd10; d.alusrc = 1'b1; end
            6'b100011, 6'b100000, 6'b100001: begin
                d.cls          = C_LOAD;
                d.aluop        = 4'd6;
                d.alusrc       = 1'b1;
                d.memtoreg     = 1'b0;
                d.ls_control   = (op != 6'b100011);
                d.ls_secontrol = (op == 6'b100001);
            end
            6'b101011, 6'b101000, 6'b101001: begin
                d.cls          = C_STORE;
                d.aluop        = 4'd6;
                d.alusrc       = 1'b1;
                d.ls_control   = (op != 6'b101011);
                d.ls_secontrol = (op == 6'b101001);
                d.memwrite_s   = (op == 6'b101000) ? 2'd1 : ((op == 6'b101001) ? 2'd2 : 2'd0);
            end
            6'b000111, 6'b000110: begin
                d.cls          = C_BRANCH;
                d.aluop        = 4'd11;
                d.comp_control = (op == 6'b000110);
            end
            6'b000001: begin d.cls = C_BRANCH; d.aluop = 4'd12; d.comp_control = b17; end
            6'b000100, 6'b000101: begin
                d.cls          = C_BRANCH;
                d.aluop        = 4'd13;
                d.comp_control = (op == 6'b000101);
            end
            6'b000010: d.cls = C_J;
            6'b000011: d.cls = C_JAL;
            default:   d.cls = C_ILL;
        endcase
        return d;
    endfunction

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           live;
    logic           dvalid;
    logic [5:0]     op_q;
    logic           b17_q;
    dec_t           in_dec;
    dec_t           q_dec;
    logic           fetch_last;
    logic           exec_last;
    logic           mem_last;
    logic           en;

    assign in_dec     = decode(bus.opcode, bus.bit17);
    assign q_dec      = decode(op_q, b17_q);
    assign fetch_last = (cnt == CW'(IMEM_LAT - 1));
    assign mem_last   = (cnt == CW'(DMEM_LAT - 1));
    assign exec_last  = (q_dec.cls != C_MUL) || (cnt == CW'(MUL_LAT - 1));
    assign en         = live && !bus.stall && !rst;

    // The first cycle after reset is an idle FETCH; sequencing starts once live is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            cnt    <= '0;
            live   <= 1'b0;
            dvalid <= 1'b0;
            op_q   <= '0;
            b17_q  <= 1'b0;
        end else if (bus.stall) begin
            state <= state;
        end else if (!live) begin
            live <= 1'b1;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_last) begin
                        state <= S_DECODE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DECODE: begin
                    op_q   <= bus.opcode;
                    b17_q  <= bus.bit17;
                    dvalid <= 1'b1;
                    cnt    <= '0;
                    if (in_dec.cls == C_J || in_dec.cls == C_JAL || in_dec.cls == C_ILL)
                        state <= S_FETCH;
                    else
                        state <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_last) begin
                        cnt <= '0;
                        case (q_dec.cls)
                            C_BRANCH:        state <= S_FETCH;
                            C_LOAD, C_STORE: state <= S_MEM;
                            default:         state <= S_WB;
                        endcase
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_MEM: begin
                    if (mem_last) begin
                        cnt   <= '0;
                        state <= (q_dec.cls == C_LOAD) ? S_WB : S_FETCH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Per-state strobes; DECODE needs the live opcode, so these are decoded from state.
    always_comb begin
        bus.pcwrite     = 1'b0;
        bus.pcwritecond = 1'b0;
        bus.irwrite     = 1'b0;
        bus.regwrite    = 1'b0;
        bus.hilowrite   = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.iord        = 1'b0;
        bus.jump        = 1'b0;
        bus.link        = 1'b0;
        bus.illegal     = 1'b0;
        if (en) begin
            case (state)
                S_FETCH: begin
                    bus.memread = 1'b1;
                    if (fetch_last) begin
                        bus.irwrite = 1'b1;
                        bus.pcwrite = 1'b1;
                    end
                end
                S_DECODE: begin
                    case (in_dec.cls)
                        C_J: begin
                            bus.pcwrite = 1'b1;
                            bus.jump    = 1'b1;
                        end
                        C_JAL: begin
                            bus.pcwrite  = 1'b1;
                            bus.jump     = 1'b1;
                            bus.link     = 1'b1;
                            bus.regwrite = 1'b1;
                        end
                        C_ILL:   bus.illegal = 1'b1;
                        default: bus.illegal = 1'b0;
                    endcase
                end
                S_EXEC: bus.pcwritecond = (q_dec.cls == C_BRANCH);
                S_MEM: begin
                    bus.iord     = 1'b1;
                    bus.memread  = (q_dec.cls == C_LOAD);
                    bus.memwrite = (q_dec.cls == C_STORE) && mem_last;
                end
                S_WB: begin
                    bus.hilowrite = (q_dec.cls == C_MUL);
                    bus.regwrite  = (q_dec.cls != C_MUL);
                end
                default: bus.iord = 1'b0;
            endcase
        end
    end

    assign bus.aluop        = dvalid ? q_dec.aluop        : 4'd0;
    assign bus.alusrc       = dvalid && q_dec.alusrc;
    assign bus.regdst       = dvalid && q_dec.regdst;
    assign bus.memtoreg     = dvalid && q_dec.memtoreg;
    assign bus.secontrol    = dvalid && q_dec.secontrol;
    assign bus.ls_control   = dvalid && q_dec.ls_control;
    assign bus.ls_secontrol = dvalid && q_dec.ls_secontrol;
    assign bus.comp_control = dvalid && q_dec.comp_control;
    assign bus.d_memwrite_s = dvalid ? q_dec.memwrite_s   : 2'd0;
    assign bus.state        = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction model pushes expected
// per-cycle state/strobes/fields, and each DUT cycle pops and compares one entry.
module tb_multicycle_controller;
    localparam int IMEM_LAT = 1;
    localparam int DMEM_LAT = 3;
    localparam int MUL_LAT  = 2;

    localparam int PCW = 10, PCC = 9, IRW = 8, RW = 7, HLW = 6, MR = 5;
    localparam int MW  = 4,  IOD = 3, JMP = 2, LNK = 1, ILL = 0;

    typedef struct {
        logic [2:0]  st;
        logic [10:0] strb;
        bit          chk;
        logic [12:0] flds;
    } exp_t;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFail;
    exp_t sb[$];

    multicycle_controller_if bus ();

    multicycle_controller #(
        .IMEM_LAT (IMEM_LAT),
        .DMEM_LAT (DMEM_LAT),
        .MUL_LAT  (MUL_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [10:0] obsStrb();
        return {bus.pcwrite, bus.pcwritecond, bus.irwrite, bus.regwrite, bus.hilowrite,
                bus.memread, bus.memwrite, bus.iord, bus.jump, bus.link, bus.illegal};
    endfunction

    function automatic logic [12:0] obsFlds();
        return {bus.aluop, bus.alusrc, bus.regdst, bus.memtoreg, bus.secontrol,
                bus.ls_control, bus.ls_secontrol, bus.comp_control, bus.d_memwrite_s};
    endfunction

    // Reference decode: class 0 alu, 1 mul, 2 load, 3 store, 4 branch, 5 j, 6 jal, 7 illegal.
    task automatic modelDecode(input logic [5:0] op, input logic b17,
                               output int c, output logic [12:0] f);
        logic [3:0] alu;
        logic       asrc, rdst, m2r, se, ls, lsse, comp;
        logic [1:0] ms;
        alu = 4'd0; asrc = 0; rdst = 0; m2r = 1; se = 1; ls = 0; lsse = 0; comp = 0; ms = 2'd0;
        c = 7;
        case (op)
            6'h00: begin c = 0; rdst = 1; end
            6'h1c: begin c = 1; alu = 4'd1; rdst = 1; end
            6'h1f: begin c = 0; alu = 4'd2; rdst = 1; end
            6'h0c: begin c = 0; alu = 4'd3; asrc = 1; se = 0; end
            6'h0d: begin c = 0; alu = 4'd4; asrc = 1; se = 0; end
            6'h0e: begin c = 0; alu = 4'd5; asrc = 1; se = 0; end
            6'h08: begin c = 0; alu = 4'd6; asrc = 1; end
            6'h09: begin c = 0; alu = 4'd7; asrc = 1; end
            6'h0a: begin c = 0; alu = 4'd8; asrc = 1; end
            6'h0b: begin c = 0; alu = 4'd9; asrc = 1; end
            6'h0f: begin c = 0; alu = 4'd10; asrc = 1; end
            6'h23: begin c = 2; alu = 4'd6; asrc = 1; m2r = 0; end
            6'h20: begin c = 2; alu = 4'd6; asrc = 1; m2r = 0; ls = 1; end
            6'h21: begin c = 2; alu = 4'd6; asrc = 1; m2r = 0; ls = 1; lsse = 1; end
            6'h2b: begin c = 3; alu = 4'd6; asrc = 1; end
            6'h28: begin c = 3; alu = 4'd6; asrc = 1; ls = 1; ms = 2'd1; end
            6'h29: begin c = 3; alu = 4'd6; asrc = 1; ls = 1; lsse = 1; ms = 2'd2; end
            6'h07: begin c = 4; alu = 4'd11; end
            6'h06: begin c = 4; alu = 4'd11; comp = 1; end
            6'h01: begin c = 4; alu = 4'd12; comp = b17; end
            6'h04: begin c = 4; alu = 4'd13; end
            6'h05: begin c = 4; alu = 4'd13; comp = 1; end
            6'h02: c = 5;
            6'h03: c = 6;
            default: c = 7;
        endcase
        f = {alu, asrc, rdst, m2r, se, ls, lsse, comp, ms};
    endtask

    // Push the full expected cycle sequence of one instruction onto the scoreboard.
    task automatic pushInstr(input logic [5:0] op, input logic b17);
        exp_t        e;
        int          c;
        logic [12:0] f;
        modelDecode(op, b17, c, f);
        for (int i = 0; i < IMEM_LAT; i++) begin
            e = '{st: 3'd0, strb: '0, chk: 1'b0, flds: f};
            e.strb[MR] = 1'b1;
            if (i == IMEM_LAT - 1) begin e.strb[IRW] = 1'b1; e.strb[PCW] = 1'b1; end
            sb.push_back(e);
        end
        e = '{st: 3'd1, strb: '0, chk: 1'b0, flds: f};
        if (c == 5 || c == 6) begin e.strb[PCW] = 1'b1; e.strb[JMP] = 1'b1; end
        if (c == 6) begin e.strb[LNK] = 1'b1; e.strb[RW] = 1'b1; end
        if (c == 7) e.strb[ILL] = 1'b1;
        sb.push_back(e);
        if (c >= 5) return;
        for (int i = 0; i < ((c == 1) ? MUL_LAT : 1); i++) begin
            e = '{st: 3'd2, strb: '0, chk: 1'b1, flds: f};
            if (c == 4) e.strb[PCC] = 1'b1;
            sb.push_back(e);
        end
        if (c == 4) return;
        if (c == 2 || c == 3) begin
            for (int i = 0; i < DMEM_LAT; i++) begin
                e = '{st: 3'd3, strb: '0, chk: 1'b1, flds: f};
                e.strb[IOD] = 1'b1;
                if (c == 2) e.strb[MR] = 1'b1;
                if (c == 3 && i == DMEM_LAT - 1) e.strb[MW] = 1'b1;
                sb.push_back(e);
            end
            if (c == 3) return;
        end
        e = '{st: 3'd4, strb: '0, chk: 1'b1, flds: f};
        if (c == 1) e.strb[HLW] = 1'b1;
        else        e.strb[RW]  = 1'b1;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        nChecks++;
        assert (bus.state === e.st) else begin
            nFail++;
            $error("[TB] FAIL %s state: got %0d expected %0d", tag, bus.state, e.st);
        end
        nChecks++;
        assert (obsStrb() === e.strb) else begin
            nFail++;
            $error("[TB] FAIL %s strobes: got %b expected %b", tag, obsStrb(), e.strb);
        end
        if (e.chk) begin
            nChecks++;
            assert (obsFlds() === e.flds) else begin
                nFail++;
                $error("[TB] FAIL %s fields: got %b expected %b", tag, obsFlds(), e.flds);
            end
        end
    endtask

    // Run one instruction; optionally freeze the first MEM cycle with stall for 3 cycles.
    task automatic applyStimulus(input logic [5:0] op, input logic b17, input bit stallMem);
        exp_t e;
        exp_t frozen;
        bit   stalled;
        stalled     = 1'b0;
        bus.opcode  = op;
        bus.bit17   = b17;
        pushInstr(op, b17);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (stallMem && !stalled && e.st == 3'd3) begin
                stalled   = 1'b1;
                frozen    = e;
                frozen.strb = '0;
                bus.stall = 1'b1;
                #1;
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) begin @(posedge clk); #1; end
                    checkOutput($sformatf("op%02h_stall%0d", op, k), frozen);
                end
                bus.stall = 1'b0;
                #1;
            end
            checkOutput($sformatf("op%02h_st%0d", op, e.st), e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkPostReset(input string tag);
        exp_t e;
        e = '{st: 3'd0, strb: '0, chk: 1'b1, flds: '0};
        checkOutput(tag, e);
    endtask

    initial begin
        nChecks    = 0;
        nFail      = 0;
        rst        = 1'b1;
        bus.opcode = 6'h00;
        bus.bit17  = 1'b0;
        bus.stall  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkPostReset("post_reset");
        @(posedge clk);
        #1;

        applyStimulus(6'h00, 1'b0, 1'b0);
        applyStimulus(6'h23, 1'b0, 1'b0);
        applyStimulus(6'h29, 1'b0, 1'b0);
        applyStimulus(6'h01, 1'b1, 1'b0);
        applyStimulus(6'h01, 1'b0, 1'b0);
        applyStimulus(6'h03, 1'b0, 1'b0);
        applyStimulus(6'h02, 1'b0, 1'b0);
        applyStimulus(6'h1c, 1'b0, 1'b0);
        applyStimulus(6'h0c, 1'b0, 1'b0);
        applyStimulus(6'h28, 1'b0, 1'b0);
        applyStimulus(6'h06, 1'b0, 1'b0);
        applyStimulus(6'h21, 1'b0, 1'b1);
        applyStimulus(6'h3f, 1'b0, 1'b0);
        applyStimulus(6'h1f, 1'b0, 1'b0);

        // Abort a load mid-MEM with reset; nothing may strobe on the reset cycle.
        bus.opcode = 6'h23;
        for (int i = 0; i < 20 && bus.state !== 3'd3; i++) begin
            @(posedge clk);
            #1;
        end
        nChecks++;
        assert (bus.state === 3'd3) else begin
            nFail++;
            $error("[TB] FAIL reach_mem: got %0d expected %0d", bus.state, 3'd3);
        end
        rst = 1'b1;
        #1;
        nChecks++;
        assert (obsStrb() === 11'd0) else begin
            nFail++;
            $error("[TB] FAIL rst_cycle_strobes: got %b expected %b", obsStrb(), 11'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkPostReset("post_abort_reset");
        @(posedge clk);
        #1;
        applyStimulus(6'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
